// File: rtl/cl_sde_pkg.sv
// Shared constants and types for the result packer: default geometry, result mode tag and
// serializer state.
package cl_sde_pkg;

   localparam int unsigned DEF_LANE_W  = 16;
   localparam int unsigned DEF_N_LANES = 64;
   localparam int unsigned DEF_N_CLS   = 10;
   localparam int unsigned DEF_OUT_W   = 512;
   localparam int unsigned DEF_DEPTH   = 4;
   localparam int unsigned DEF_CNT_W   = 32;

   typedef enum logic {
      MODE_FULL = 1'b0,
      MODE_CLS  = 1'b1
   } mode_e;

   typedef enum logic {
      StIdle = 1'b0,
      StSend = 1'b1
   } state_e;

   function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/cl_sde_res_fifo.sv
// Synchronous FIFO of mode-tagged result vectors. Exposes the head entry and the entry behind
// it so the serializer can chain packets without a bubble.
module cl_sde_res_fifo #(
   parameter int unsigned WIDTH = 1025,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] rd_data_next,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_push  = push && (count_q != CW'(DEPTH));
      do_pop   = pop && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; only entries covered by count are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data      = mem_q[rd_ptr_q];
   assign rd_data_next = mem_q[rd_ptr_q + AW'(1)];
   assign count        = count_q;

endmodule

// File: rtl/cl_sde_res_packer.sv
// Buffers result vectors and serializes each into OUT_W-wide beats, either the full vector or
// only the class lanes, with byte enables and end-of-result marking.
module cl_sde_res_packer
   import cl_sde_pkg::*;
#(
   parameter int unsigned LANE_W  = DEF_LANE_W,
   parameter int unsigned N_LANES = DEF_N_LANES,
   parameter int unsigned N_CLS   = DEF_N_CLS,
   parameter int unsigned OUT_W   = DEF_OUT_W,
   parameter int unsigned DEPTH   = DEF_DEPTH,
   parameter int unsigned CNT_W   = DEF_CNT_W
) (
   input  logic                      clk,
   input  logic                      srst,
   input  logic                      res_valid,
   input  logic [N_LANES*LANE_W-1:0] res_data,
   output logic                      res_ready,
   input  logic                      mode,
   output logic                      ots_valid,
   output logic [OUT_W-1:0]          ots_data,
   output logic [OUT_W/8-1:0]        ots_keep,
   output logic                      ots_last,
   input  logic                      ots_ready,
   input  logic                      stat_clr,
   output logic [CNT_W-1:0]          stat_res_in,
   output logic [CNT_W-1:0]          stat_beats,
   output logic [CNT_W-1:0]          stat_drops,
   output logic                      busy
);

   localparam int unsigned P_FULL = N_LANES * LANE_W;
   localparam int unsigned P_CLS  = N_CLS * LANE_W;
   localparam int unsigned B_FULL = ceil_div(P_FULL, OUT_W);
   localparam int unsigned B_CLS  = ceil_div(P_CLS, OUT_W);
   localparam int unsigned KEEP_W = OUT_W / 8;
   localparam int unsigned PAD_W  = B_FULL * OUT_W;
   localparam int unsigned BEAT_W = (B_FULL > 1) ? $clog2(B_FULL) : 1;
   localparam int unsigned ENT_W  = 1 + P_FULL;
   localparam int unsigned FCW    = $clog2(DEPTH + 1);
   localparam logic [PAD_W-1:0] CLS_MASK = {PAD_W{1'b1}} >> (PAD_W - P_CLS);

   logic              fifo_push, fifo_pop;
   logic [ENT_W-1:0]  head, head_next;
   logic [FCW-1:0]    fifo_cnt;

   state_e            state_q, state_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              ots_valid_q, ots_valid_d;
   logic [OUT_W-1:0]  ots_data_q, ots_data_d;
   logic [KEEP_W-1:0] ots_keep_q, ots_keep_d;
   logic              ots_last_q, ots_last_d;
   logic [CNT_W-1:0]  stat_res_in_q, stat_res_in_d;
   logic [CNT_W-1:0]  stat_beats_q, stat_beats_d;
   logic [CNT_W-1:0]  stat_drops_q, stat_drops_d;

   logic              load;
   logic [ENT_W-1:0]  src_ent;
   logic [BEAT_W-1:0] src_k;
   logic              cls;
   int                k_int, rem;
   logic [PAD_W-1:0]  pay, shifted;
   logic [OUT_W-1:0]  beat_data;
   logic [KEEP_W-1:0] beat_keep;
   logic              beat_last;

   assign res_ready = (fifo_cnt != FCW'(DEPTH));
   assign fifo_push = res_valid && res_ready;

   // The entry being sent stays in the FIFO until its last beat leaves, so it counts toward
   // occupancy.
   cl_sde_res_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .srst         (srst),
      .push         (fifo_push),
      .wr_data      ({mode, res_data}),
      .pop          (fifo_pop),
      .rd_data      (head),
      .rd_data_next (head_next),
      .count        (fifo_cnt)
   );

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      ots_valid_d = ots_valid_q;
      ots_data_d  = ots_data_q;
      ots_keep_d  = ots_keep_q;
      ots_last_d  = ots_last_q;
      fifo_pop    = 1'b0;
      load        = 1'b0;
      src_ent     = head;
      src_k       = '0;

      unique case (state_q)
         StIdle: begin
            if (fifo_cnt != '0) state_d = StSend;
         end
         StSend: begin
            if (!ots_valid_q) begin
               load = 1'b1;
            end else if (ots_ready) begin
               if (!ots_last_q) begin
                  load  = 1'b1;
                  src_k = beat_q + BEAT_W'(1);
               end else begin
                  fifo_pop = 1'b1;
                  // Chain straight into the next buffered result.
                  if (fifo_cnt > FCW'(1)) begin
                     load    = 1'b1;
                     src_ent = head_next;
                  end else begin
                     state_d     = StIdle;
                     ots_valid_d = 1'b0;
                     ots_data_d  = '0;
                     ots_keep_d  = '0;
                     ots_last_d  = 1'b0;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase

      cls   = (mode_e'(src_ent[ENT_W-1]) == MODE_CLS);
      k_int = int'(src_k);
      pay   = PAD_W'(src_ent[P_FULL-1:0]);
      if (cls) pay = pay & CLS_MASK;
      shifted   = pay >> (k_int * int'(OUT_W));
      beat_data = shifted[OUT_W-1:0];
      rem       = (cls ? int'(P_CLS) : int'(P_FULL)) - k_int * int'(OUT_W);
      for (int j = 0; j < int'(KEEP_W); j++) begin
         beat_keep[j] = ((j * 8) < rem);
      end
      beat_last = (k_int == ((cls ? int'(B_CLS) : int'(B_FULL)) - 1));

      if (load) begin
         ots_valid_d = 1'b1;
         ots_data_d  = beat_data;
         ots_keep_d  = beat_keep;
         ots_last_d  = beat_last;
         beat_d      = src_k;
      end
   end

   always_comb begin
      stat_res_in_d = stat_res_in_q;
      stat_beats_d  = stat_beats_q;
      stat_drops_d  = stat_drops_q;
      if (stat_clr) begin
         stat_res_in_d = '0;
         stat_beats_d  = '0;
         stat_drops_d  = '0;
      end else begin
         if (fifo_push)                stat_res_in_d = stat_res_in_q + CNT_W'(1);
         if (ots_valid_q && ots_ready) stat_beats_d  = stat_beats_q + CNT_W'(1);
         if (res_valid && !res_ready)  stat_drops_d  = stat_drops_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q       <= StIdle;
         beat_q        <= '0;
         ots_valid_q   <= 1'b0;
         ots_data_q    <= '0;
         ots_keep_q    <= '0;
         ots_last_q    <= 1'b0;
         stat_res_in_q <= '0;
         stat_beats_q  <= '0;
         stat_drops_q  <= '0;
      end else begin
         state_q       <= state_d;
         beat_q        <= beat_d;
         ots_valid_q   <= ots_valid_d;
         ots_data_q    <= ots_data_d;
         ots_keep_q    <= ots_keep_d;
         ots_last_q    <= ots_last_d;
         stat_res_in_q <= stat_res_in_d;
         stat_beats_q  <= stat_beats_d;
         stat_drops_q  <= stat_drops_d;
      end
   end

   assign ots_valid   = ots_valid_q;
   assign ots_data    = ots_data_q;
   assign ots_keep    = ots_keep_q;
   assign ots_last    = ots_last_q;
   assign stat_res_in = stat_res_in_q;
   assign stat_beats  = stat_beats_q;
   assign stat_drops  = stat_drops_q;
   assign busy        = (fifo_cnt != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_cl_sde_res_packer.sv
// Directed and randomized checks of the result packer at default geometry, plus a narrow-counter
// instance for statistics wrap-around.
module tb_cl_sde_res_packer;

   localparam int LW = 16;
   localparam int NL = 64;
   localparam int OW = 512;
   localparam int KW = 64;
   localparam int DW = NL * LW;

   typedef logic [576:0] beat_t;  // {last, keep, data}

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          srst, res_valid, mode, ots_ready, stat_clr;
   logic [DW-1:0] res_data;
   logic          res_ready, ots_valid, ots_last, busy;
   logic [OW-1:0] ots_data;
   logic [KW-1:0] ots_keep;
   logic [31:0]   stat_res_in, stat_beats, stat_drops;

   logic          w_res_valid, w_res_ready, w_ots_valid, w_ots_last, w_busy;
   logic [OW-1:0] w_ots_data;
   logic [KW-1:0] w_ots_keep;
   logic [3:0]    w_res_in, w_beats, w_drops;

   cl_sde_res_packer dut (
      .clk         (clk),
      .srst        (srst),
      .res_valid   (res_valid),
      .res_data    (res_data),
      .res_ready   (res_ready),
      .mode        (mode),
      .ots_valid   (ots_valid),
      .ots_data    (ots_data),
      .ots_keep    (ots_keep),
      .ots_last    (ots_last),
      .ots_ready   (ots_ready),
      .stat_clr    (stat_clr),
      .stat_res_in (stat_res_in),
      .stat_beats  (stat_beats),
      .stat_drops  (stat_drops),
      .busy        (busy)
   );

   cl_sde_res_packer #(.CNT_W(4)) u_wrap (
      .clk         (clk),
      .srst        (srst),
      .res_valid   (w_res_valid),
      .res_data    (res_data),
      .res_ready   (w_res_ready),
      .mode        (1'b1),
      .ots_valid   (w_ots_valid),
      .ots_data    (w_ots_data),
      .ots_keep    (w_ots_keep),
      .ots_last    (w_ots_last),
      .ots_ready   (1'b1),
      .stat_clr    (1'b0),
      .stat_res_in (w_res_in),
      .stat_beats  (w_beats),
      .stat_drops  (w_drops),
      .busy        (w_busy)
   );

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] ramp(input int base);
      logic [DW-1:0] v = '0;
      for (int i = 0; i < NL; i++) v[i*LW +: LW] = 16'(base + i);
      return v;
   endfunction

   function automatic logic [DW-1:0] rnd_vec();
      logic [DW-1:0] v = '0;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Reference beats for the default geometry: full = 2 beats, class = 160 bits in one beat.
   function automatic beat_t mk_beat(input logic [DW-1:0] v, input logic m, input int k);
      if (m) return {1'b1, 64'h0000_0000_000F_FFFF, 352'b0, v[159:0]};
      else if (k == 0) return {1'b0, {64{1'b1}}, v[511:0]};
      else return {1'b1, {64{1'b1}}, v[1023:512]};
   endfunction

   logic [DW-1:0] v0, v1, va, vb, vc, vd;
   logic [DW-1:0] vq [5];
   beat_t         exp_q [$];
   int            n0, n1;
   bit            prod_done;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      srst = 1'b1; res_valid = 1'b0; mode = 1'b0; ots_ready = 1'b0; stat_clr = 1'b0;
      res_data = '0; w_res_valid = 1'b0; n0 = 0; n1 = 0; prod_done = 1'b0;
      tick(2);
      chk("rst_valid", ots_valid, 1'b0);
      chk("rst_last", ots_last, 1'b0);
      chk("rst_keep", ots_keep, '0);
      chk("rst_data", ots_data, '0);
      chk("rst_ready", res_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_stats", {stat_res_in, stat_beats, stat_drops}, '0);
      srst = 1'b0;

      // Full-vector result, sink always ready.
      ots_ready = 1'b1; v0 = ramp(0); res_data = v0; mode = 1'b0; res_valid = 1'b1;
      tick();
      res_valid = 1'b0;
      chk("full_busy", busy, 1'b1);
      chk("full_t0_valid", ots_valid, 1'b0);
      tick();
      chk("full_t1_valid", ots_valid, 1'b0);
      tick();
      chk("full_beat0", {ots_valid, ots_last, ots_keep, ots_data}, {1'b1, mk_beat(v0, 1'b0, 0)});
      tick();
      chk("full_beat1", {ots_valid, ots_last, ots_keep, ots_data}, {1'b1, mk_beat(v0, 1'b0, 1)});
      chk("full_lane32", ots_data[15:0], 16'h0020);
      tick();
      chk("full_done", {ots_valid, busy}, 2'b00);
      chk("full_stats", {stat_res_in, stat_beats}, {32'd1, 32'd2});

      // Class-only result.
      v1 = ramp(16'h1000); res_data = v1; mode = 1'b1; res_valid = 1'b1;
      tick();
      res_valid = 1'b0;
      tick(2);
      chk("cls_beat", {ots_valid, ots_last, ots_keep, ots_data}, {1'b1, mk_beat(v1, 1'b1, 0)});
      chk("cls_keep", ots_keep, 64'h0000_0000_000F_FFFF);
      chk("cls_lane9", ots_data[159:144], 16'h1009);
      tick();
      chk("cls_done", ots_valid, 1'b0);
      chk("cls_beats", stat_beats, 32'd3);

      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk("clr_stats", {stat_res_in, stat_beats, stat_drops}, '0);

      // Overflow with a stalled sink.
      ots_ready = 1'b0; mode = 1'b0;
      for (int i = 0; i < 5; i++) begin
         vq[i] = ramp(256 * (i + 1)); res_data = vq[i]; res_valid = 1'b1;
         chk($sformatf("ovf_ready%0d", i), res_ready, (i < 4));
         tick();
      end
      res_valid = 1'b0;
      chk("ovf_hold_a", {ots_valid, ots_last, ots_keep, ots_data}, {1'b1, mk_beat(vq[0], 1'b0, 0)});
      tick(2);
      chk("ovf_hold_b", {ots_valid, ots_last, ots_keep, ots_data}, {1'b1, mk_beat(vq[0], 1'b0, 0)});
      chk("ovf_stats", {stat_res_in, stat_beats, stat_drops}, {32'd4, 32'd0, 32'd1});
      ots_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         chk($sformatf("drain_beat%0d", j), {ots_valid, ots_last, ots_keep, ots_data},
             {1'b1, mk_beat(vq[j/2], 1'b0, j % 2)});
         tick();
      end
      chk("drain_done", {ots_valid, busy}, 2'b00);
      chk("drain_beats", stat_beats, 32'd8);

      // Clear coincides with a beat transfer and an accept.
      va = ramp(16'h2000); vb = ramp(16'h3000); res_data = va; mode = 1'b1; res_valid = 1'b1;
      tick();
      res_valid = 1'b0;
      tick(2);
      chk("clrw_valid", ots_valid, 1'b1);
      stat_clr = 1'b1; res_data = vb; res_valid = 1'b1;
      tick();
      stat_clr = 1'b0; res_valid = 1'b0;
      chk("clrw_zero", {stat_res_in, stat_beats, stat_drops}, '0);
      tick(4);
      chk("clrw_after", {ots_valid, stat_res_in, stat_beats}, {1'b0, 32'd0, 32'd1});

      // Reset in the middle of a full-vector packet.
      ots_ready = 1'b0; vc = ramp(16'h4000); res_data = vc; mode = 1'b0; res_valid = 1'b1;
      tick();
      res_valid = 1'b0;
      tick(2);
      chk("srst_pre", {ots_valid, ots_last}, 2'b10);
      srst = 1'b1;
      tick();
      srst = 1'b0;
      chk("srst_out", {ots_valid, ots_last, res_ready, busy}, 4'b0010);
      chk("srst_stats", {stat_res_in, stat_beats, stat_drops}, '0);
      ots_ready = 1'b1; vd = ramp(16'h5000); res_data = vd; res_valid = 1'b1;
      tick();
      res_valid = 1'b0;
      tick(2);
      chk("srst_new0", {ots_valid, ots_last, ots_keep, ots_data}, {1'b1, mk_beat(vd, 1'b0, 0)});
      tick();
      chk("srst_new1", {ots_valid, ots_last, ots_keep, ots_data}, {1'b1, mk_beat(vd, 1'b0, 1)});
      tick();
      chk("srst_new_done", {ots_valid, stat_beats}, {1'b0, 32'd2});

      // Narrow counters wrap modulo 16.
      for (int i = 0; i < 15; i++) begin
         w_res_valid = 1'b1;
         tick();
         w_res_valid = 1'b0;
         tick(3);
      end
      chk("wrap_pre", {w_res_in, w_beats, w_drops}, {4'd15, 4'd15, 4'd0});
      w_res_valid = 1'b1;
      tick();
      w_res_valid = 1'b0;
      tick(3);
      chk("wrap_post", {w_res_in, w_beats}, {4'd0, 4'd0});

      // Random traffic with a randomly stalling sink.
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      fork
         begin : producer
            for (int r = 0; r < 100; r++) begin
               int gap;
               int bound;
               logic [DW-1:0] v;
               logic m;
               gap = $urandom_range(0, 2);
               if (gap > 0) tick(gap);
               bound = 0;
               while (!res_ready && bound < 200) begin
                  tick();
                  bound++;
               end
               if (!res_ready) chk("prod_ready_timeout", res_ready, 1'b1);
               m = 1'($urandom_range(0, 1));
               v = rnd_vec();
               res_data = v; mode = m; res_valid = 1'b1;
               if (m) begin
                  exp_q.push_back(mk_beat(v, 1'b1, 0));
                  n1++;
               end else begin
                  exp_q.push_back(mk_beat(v, 1'b0, 0));
                  exp_q.push_back(mk_beat(v, 1'b0, 1));
                  n0++;
               end
               tick();
               res_valid = 1'b0;
            end
            prod_done = 1'b1;
         end
         begin : consumer
            int    cyc;
            bit    stalled;
            beat_t held;
            cyc = 0; stalled = 1'b0; held = '0;
            while (!(prod_done && exp_q.size() == 0) && cyc < 20000) begin
               if (stalled) chk("rand_stall_hold", {ots_valid, ots_last, ots_keep, ots_data},
                                {1'b1, held});
               ots_ready = 1'($urandom_range(0, 1));
               stalled = 1'b0;
               if (ots_valid) begin
                  if (!ots_ready) begin
                     stalled = 1'b1;
                     held = {ots_last, ots_keep, ots_data};
                  end else if (exp_q.size() == 0) begin
                     chk("rand_unexpected_beat", ots_valid, 1'b0);
                  end else begin
                     chk("rand_beat", {ots_last, ots_keep, ots_data}, exp_q.pop_front());
                  end
               end
               tick();
               cyc++;
            end
            chk("rand_complete", {prod_done, exp_q.size() == 0}, 2'b11);
         end
      join
      ots_ready = 1'b1;
      tick(2);
      chk("rand_res_in", stat_res_in, 32'd100);
      chk("rand_drops", stat_drops, 32'd0);
      chk("rand_beats", stat_beats, 32'(2 * n0 + n1));
      chk("rand_idle", {ots_valid, busy}, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cl_sde_res_packer.md
CL_SDE_RES_PACKER -- requirements
Module: cl_sde_res_packer

Interface
REQ-001 SHALL have parameters: LANE_W, default 16, bits per result lane; N_LANES, default 64, lanes per result vector; N_CLS, default 10, lanes sent in class mode (1..N_LANES); OUT_W, default 512, output stream width (multiple of 8, multiple of LANE_W); DEPTH, default 4, result buffer entries (power of 2, >=2); CNT_W, default 32, statistics counter width.
REQ-002 SHALL have one clock; reset is synchronous and active-high. Ports are clk and srst.
REQ-003 SHALL have ports:
- clk  in  1  clock
- srst  in  1  synchronous active-high reset
- res_valid  in  1  result vector present (source is not backpressurable)
- res_data  in  N_LANES*LANE_W  result vector, lane i at bits [i*LANE_W +: LANE_W]
- res_ready  out  1  buffer can accept this cycle
- mode  in  1  0 = full vector, 1 = class only (lanes 0..N_CLS-1)
- ots_valid  out  1  output beat valid
- ots_data  out  OUT_W  output beat data
- ots_keep  out  OUT_W/8  byte enables
- ots_last  out  1  final beat of a result
- ots_ready  in  1  sink accepts beat
- stat_clr  in  1  clear statistics counters
- stat_res_in  out  CNT_W  results accepted
- stat_beats  out  CNT_W  beats transferred
- stat_drops  out  CNT_W  results dropped
- busy  out  1  buffer non-empty or packet in flight

Function
REQ-004 SHALL accept a result when res_valid && res_ready; SHALL store mode with the entry, so mode changes affect only later results.
REQ-005 SHALL drive res_ready = 0 when the buffer holds DEPTH entries, from registered occupancy only; a same-cycle pop does not raise res_ready.
REQ-006 SHALL count res_valid && !res_ready as a drop and discard that vector.
REQ-007 SHALL send a result as B beats. Payload bits P = N_LANES*LANE_W (mode 0) or N_CLS*LANE_W (mode 1). B = ceil(P/OUT_W).
REQ-008 SHALL place payload bit 0 at beat 0 bit 0; beat k carries payload [k*OUT_W +: OUT_W]; unused bits SHALL be 0.
REQ-009 SHALL set ots_keep all-ones on non-final beats; on the final beat, the low ceil(remaining bits/8) bits SHALL be set and the rest 0.
REQ-010 SHALL assert ots_last only on the final beat; a 1-beat result SHALL have ots_last on beat 0.
REQ-011 SHALL use an FSM IDLE/SEND. IDLE->SEND when the buffer is non-empty (pop head, load beat 0). SEND: on ots_valid && ots_ready, advance the beat. After the last beat, go to SEND with the next entry if the buffer is non-empty, else IDLE; there SHALL be no bubble between results.
REQ-012 SHALL keep ots_data/keep/last/valid registered and stable while ots_valid && !ots_ready.
REQ-013 SHALL have latency of 2 cycles from acceptance into an empty, idle block (edge t) to ots_valid high (edge t+2).
REQ-014 SHALL increment counters modulo 2^CNT_W, with no saturation. stat_clr SHALL zero all three at the next edge; clear wins over a same-cycle increment.
REQ-015 SHALL, on a simultaneous push and pop with a non-full buffer, perform both with occupancy unchanged; pointers SHALL wrap modulo DEPTH.

Reset
REQ-016 SHALL, on srst, set the following on the next edge: ots_valid=0, ots_last=0, ots_keep=0, ots_data=0, res_ready=1, busy=0, counters=0, FSM=IDLE, buffer empty.
REQ-017 SHALL, when srst is asserted mid-packet, abort the packet without emitting remaining beats or ots_last; results in flight are lost uncounted.

Structure
REQ-018 SHALL have a package cl_sde_pkg holding default parameter constants, the mode enum (MODE_FULL=0, MODE_CLS=1) and the FSM state enum.
REQ-019 SHALL contain one sub-module cl_sde_res_fifo: a synchronous FIFO of DEPTH x (1+N_LANES*LANE_W) with count output; the serializer stays in the top.

Verification
REQ-020 Defaults, mode 0, one result with lane i = i, ots_ready=1 -> 2 beats at t+2 and t+3; beat 1 lane 32 = 0x0020; keep all-ones both beats; last on beat 1.
REQ-021 Mode 1, lane i = 0x1000+i -> 1 beat; bits[159:0] = lanes 0..9; bits[511:160] = 0; keep = 0x0000_0000_000F_FFFF; last = 1.
REQ-022 5 back-to-back results, ots_ready=0 -> res_ready falls after 4 accepts; 5th counted drop; stat_res_in=4, stat_drops=1; ots_valid and data stable throughout.
REQ-023 Random ots_ready (50%), 100 mixed-mode results -> output order and content match a model; stat_beats = 2*(mode-0 count) + (mode-1 count); no bubbles when buffered.
REQ-024 srst during beat 0 of a mode-0 packet -> next cycle ots_valid=0, counters 0, res_ready=1; a new result afterwards is sent intact.
REQ-025 Preload stat_beats to 2^32-1 via traffic or force, one beat transfers -> wraps to 0; stat_clr in the same cycle as an increment -> 0.
